// File: rtl/hbm_tg_run_ctrl.sv
// ============================================================================
// Module   : hbm_tg_run_ctrl
// Purpose  : Run controller for the HBM example design. Sequences the HBM
//            controller and two traffic-generator resets, waits for
//            calibration, runs both generators and folds their status into
//            one verdict. Aborts on cattrip / over-temperature / timeouts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hbm_tg_run_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES  = 64,
    parameter int unsigned CAL_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned RUN_TIMEOUT_CYCLES = 16000000,
    parameter logic [2:0]  TEMP_LIMIT         = 3'd5,
    parameter int unsigned CNT_W              = 32
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       start,
    input  logic       cal_success,
    input  logic       cal_fail,
    input  logic       cattrip,
    input  logic [2:0] temp,
    input  logic [1:0] tg_pass,
    input  logic [1:0] tg_fail,
    input  logic [1:0] tg_timeout,
    output logic       hbm_reset_n,
    output logic [1:0] tg_reset_n,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_code,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_WAIT_CAL = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4,
        S_ABORT    = 3'd5
    } state_t;

    localparam logic [2:0] c_err_none     = 3'd0;
    localparam logic [2:0] c_err_cal_fail = 3'd1;
    localparam logic [2:0] c_err_cal_tmo  = 3'd2;
    localparam logic [2:0] c_err_tg_fail  = 3'd3;
    localparam logic [2:0] c_err_tg_tmo   = 3'd4;
    localparam logic [2:0] c_err_run_tmo  = 3'd5;
    localparam logic [2:0] c_err_cattrip  = 3'd6;
    localparam logic [2:0] c_err_ovtemp   = 3'd7;

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cal_last  = CNT_W'(CAL_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_run_last  = CNT_W'(RUN_TIMEOUT_CYCLES - 1);

    // Internal reset: asserts immediately with reset_reset_n, releases two
    // clocks later so nothing (including a start pulse) is acted on at the
    // release edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Reset synchroniser: async assert, sync deassert
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt, w_cnt_inc;
    logic             r_hbm_reset_n, w_nxt_hbm_reset_n;
    logic [1:0]       r_tg_reset_n, w_nxt_tg_reset_n;
    logic             r_busy, w_nxt_busy;
    logic             r_done, w_nxt_done;
    logic             r_pass, w_nxt_pass;
    logic [2:0]       r_err, w_nxt_err;
    logic [1:0]       r_fin, w_nxt_fin;   // generator finished (latched)
    logic [1:0]       r_fail, w_nxt_fail; // generator finished with fail
    logic [1:0]       r_tmo, w_nxt_tmo;   // generator finished with timeout
    logic             w_abort;
    logic [2:0]       w_abort_code;
    logic             w_therm_active;

    // State and output registers
    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hbm_reset_n <= 1'b0;
            r_tg_reset_n  <= 2'b00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= c_err_none;
            r_fin         <= 2'b00;
            r_fail        <= 2'b00;
            r_tmo         <= 2'b00;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_hbm_reset_n <= w_nxt_hbm_reset_n;
            r_tg_reset_n  <= w_nxt_tg_reset_n;
            r_busy        <= w_nxt_busy;
            r_done        <= w_nxt_done;
            r_pass        <= w_nxt_pass;
            r_err         <= w_nxt_err;
            r_fin         <= w_nxt_fin;
            r_fail        <= w_nxt_fail;
            r_tmo         <= w_nxt_tmo;
        end
    end

    // Next-state and next-output decode; thermal abort overrides everything
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_cnt         = r_cnt;
        w_nxt_hbm_reset_n = r_hbm_reset_n;
        w_nxt_tg_reset_n  = r_tg_reset_n;
        w_nxt_busy        = r_busy;
        w_nxt_done        = r_done;
        w_nxt_pass        = r_pass;
        w_nxt_err         = r_err;
        w_nxt_fin         = r_fin;
        w_nxt_fail        = r_fail;
        w_nxt_tmo         = r_tmo;
        w_abort           = 1'b0;
        w_abort_code      = c_err_none;
        // Saturating increment: the counter never wraps
        w_cnt_inc         = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
        w_therm_active    = (r_state == S_RST_HOLD) || (r_state == S_WAIT_CAL) ||
                            (r_state == S_RUN);

        case (r_state)
            S_IDLE, S_DONE, S_ABORT: begin
                if (start) begin
                    w_nxt_state       = S_RST_HOLD;
                    w_nxt_cnt         = '0;
                    w_nxt_hbm_reset_n = 1'b0;
                    w_nxt_tg_reset_n  = 2'b00;
                    w_nxt_busy        = 1'b1;
                    w_nxt_done        = 1'b0;
                    w_nxt_pass        = 1'b0;
                    w_nxt_err         = c_err_none;
                    w_nxt_fin         = 2'b00;
                    w_nxt_fail        = 2'b00;
                    w_nxt_tmo         = 2'b00;
                end
            end
            S_RST_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_nxt_hbm_reset_n = 1'b1;
                    w_nxt_cnt         = '0;
                    w_nxt_state       = S_WAIT_CAL;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end
            S_WAIT_CAL: begin
                if (cal_fail) begin
                    w_abort      = 1'b1;
                    w_abort_code = c_err_cal_fail;
                end else if (cal_success) begin
                    w_nxt_tg_reset_n = 2'b11;
                    w_nxt_cnt        = '0;
                    w_nxt_state      = S_RUN;
                end else if (r_cnt == c_cal_last) begin
                    w_abort      = 1'b1;
                    w_abort_code = c_err_cal_tmo;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end
            S_RUN: begin
                // Latch the first status seen per generator; later status
                // from an already-finished generator is ignored.
                for (int i = 0; i < 2; i++) begin
                    if (!r_fin[i] && (tg_pass[i] || tg_fail[i] || tg_timeout[i])) begin
                        w_nxt_fin[i] = 1'b1;
                        if (tg_fail[i]) begin
                            w_nxt_fail[i] = 1'b1;
                        end else if (tg_timeout[i]) begin
                            w_nxt_tmo[i] = 1'b1;
                        end
                    end
                end
                if (&w_nxt_fin) begin
                    w_nxt_state = S_DONE;
                    w_nxt_busy  = 1'b0;
                    w_nxt_done  = 1'b1;
                    if (|w_nxt_fail) begin
                        w_nxt_err = c_err_tg_fail;
                    end else if (|w_nxt_tmo) begin
                        w_nxt_err = c_err_tg_tmo;
                    end else begin
                        w_nxt_pass = 1'b1;
                        w_nxt_err  = c_err_none;
                    end
                end else if (r_cnt == c_run_last) begin
                    w_abort      = 1'b1;
                    w_abort_code = c_err_run_tmo;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (w_therm_active && cattrip) begin
            w_abort      = 1'b1;
            w_abort_code = c_err_cattrip;
        end else if (w_therm_active && (temp >= TEMP_LIMIT)) begin
            w_abort      = 1'b1;
            w_abort_code = c_err_ovtemp;
        end

        if (w_abort) begin
            w_nxt_state       = S_ABORT;
            w_nxt_hbm_reset_n = 1'b0;
            w_nxt_tg_reset_n  = 2'b00;
            w_nxt_busy        = 1'b0;
            w_nxt_done        = 1'b1;
            w_nxt_pass        = 1'b0;
            w_nxt_err         = w_abort_code;
        end
    end

    assign hbm_reset_n = r_hbm_reset_n;
    assign tg_reset_n  = r_tg_reset_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_code    = r_err;
    assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_hbm_tg_run_ctrl.sv
// ============================================================================
// Module   : tb_hbm_tg_run_ctrl
// Purpose  : Directed self-checking bench for hbm_tg_run_ctrl with short
//            hold/timeout parameters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hbm_tg_run_ctrl;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       start = 1'b0;
    logic       cal_success = 1'b0;
    logic       cal_fail = 1'b0;
    logic       cattrip = 1'b0;
    logic [2:0] temp = 3'd0;
    logic [1:0] tg_pass = 2'b00;
    logic [1:0] tg_fail = 2'b00;
    logic [1:0] tg_timeout = 2'b00;
    logic       hbm_reset_n;
    logic [1:0] tg_reset_n;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_code;
    logic [2:0] state;

    int n_chk = 0;
    int n_ok  = 0;

    hbm_tg_run_ctrl #(
        .RESET_HOLD_CYCLES (4),
        .CAL_TIMEOUT_CYCLES(20),
        .RUN_TIMEOUT_CYCLES(30),
        .TEMP_LIMIT        (3'd5),
        .CNT_W             (32)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .start        (start),
        .cal_success  (cal_success),
        .cal_fail     (cal_fail),
        .cattrip      (cattrip),
        .temp         (temp),
        .tg_pass      (tg_pass),
        .tg_fail      (tg_fail),
        .tg_timeout   (tg_timeout),
        .hbm_reset_n  (hbm_reset_n),
        .tg_reset_n   (tg_reset_n),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_code     (err_code),
        .state        (state)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Advance n clocks; inputs change and outputs are sampled 1ns after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // From IDLE/DONE/ABORT: start, sit through the hold, calibrate, enter RUN
    task automatic enter_run();
        pulse_start();
        tick(4);
        cal_success = 1'b1;
        tick(1);
        cal_success = 1'b0;
        n_chk++; if (state !== 3'd3) $display("FAIL enter_run_state: got %0d expected 3", state); else n_ok++;
    endtask

    task automatic test_reset();
        tick(3);
        n_chk++; if (state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state); else n_ok++;
        n_chk++; if (hbm_reset_n !== 1'b0) $display("FAIL rst_hbm: got %b expected 0", hbm_reset_n); else n_ok++;
        n_chk++; if (tg_reset_n !== 2'b00) $display("FAIL rst_tg: got %b expected 00", tg_reset_n); else n_ok++;
        n_chk++; if ({busy, done, pass} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {busy, done, pass}); else n_ok++;
        n_chk++; if (err_code !== 3'd0) $display("FAIL rst_err: got %0d expected 0", err_code); else n_ok++;
        // start held across the reset release edges must not launch a run
        reset_reset_n = 1'b1;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        tick(2);
        n_chk++; if (state !== 3'd0) $display("FAIL start_at_release: got %0d expected 0", state); else n_ok++;
        n_chk++; if (busy !== 1'b0) $display("FAIL start_at_release_busy: got %b expected 0", busy); else n_ok++;
    endtask

    task automatic test_nominal();
        pulse_start();
        n_chk++; if (state !== 3'd1) $display("FAIL nom_rst_hold: got %0d expected 1", state); else n_ok++;
        n_chk++; if (busy !== 1'b1) $display("FAIL nom_busy: got %b expected 1", busy); else n_ok++;
        tick(3);
        n_chk++; if (hbm_reset_n !== 1'b0) $display("FAIL nom_hbm_held: got %b expected 0", hbm_reset_n); else n_ok++;
        tick(1);
        n_chk++; if (hbm_reset_n !== 1'b1) $display("FAIL nom_hbm_rise: got %b expected 1", hbm_reset_n); else n_ok++;
        n_chk++; if (state !== 3'd2) $display("FAIL nom_wait_cal: got %0d expected 2", state); else n_ok++;
        tick(5);
        cal_success = 1'b1;
        tick(1);
        cal_success = 1'b0;
        n_chk++; if (tg_reset_n !== 2'b11) $display("FAIL nom_tg_release: got %b expected 11", tg_reset_n); else n_ok++;
        n_chk++; if (state !== 3'd3) $display("FAIL nom_run: got %0d expected 3", state); else n_ok++;
        tick(2);
        tg_pass = 2'b01;
        tick(1);
        tg_pass = 2'b00;
        n_chk++; if ({state, done} !== {3'd3, 1'b0}) $display("FAIL nom_half_done: got %0d/%b expected 3/0", state, done); else n_ok++;
        tick(4);
        tg_pass = 2'b11;
        tick(1);
        tg_pass = 2'b00;
        n_chk++; if ({done, pass, busy} !== 3'b110) $display("FAIL nom_verdict: got %b expected 110", {done, pass, busy}); else n_ok++;
        n_chk++; if (err_code !== 3'd0) $display("FAIL nom_err: got %0d expected 0", err_code); else n_ok++;
        tick(2);
        n_chk++; if ({state, hbm_reset_n, tg_reset_n} !== {3'd4, 1'b1, 2'b11}) $display("FAIL nom_done_hold: got %0d/%b/%b expected 4/1/11", state, hbm_reset_n, tg_reset_n); else n_ok++;
    endtask

    task automatic test_tg_fail();
        enter_run();
        tg_fail = 2'b10;
        tg_pass = 2'b01;
        tick(1);
        tg_fail = 2'b00;
        tg_pass = 2'b00;
        n_chk++; if ({state, done, pass} !== {3'd4, 1'b1, 1'b0}) $display("FAIL tgf_verdict: got %0d/%b/%b expected 4/1/0", state, done, pass); else n_ok++;
        n_chk++; if (err_code !== 3'd3) $display("FAIL tgf_err: got %0d expected 3", err_code); else n_ok++;
        n_chk++; if (tg_reset_n !== 2'b11) $display("FAIL tgf_tg_reset: got %b expected 11", tg_reset_n); else n_ok++;
        // fail beats timeout on one generator, status after latch is ignored
        enter_run();
        n_chk++; if ({done, err_code} !== {1'b0, 3'd0}) $display("FAIL restart_clear: got %b/%0d expected 0/0", done, err_code); else n_ok++;
        tg_fail = 2'b01;
        tg_timeout = 2'b01;
        tick(1);
        tg_fail = 2'b00;
        tg_timeout = 2'b00;
        tg_pass = 2'b11;
        tick(1);
        tg_pass = 2'b00;
        n_chk++; if ({done, pass, err_code} !== {1'b1, 1'b0, 3'd3}) $display("FAIL fail_over_tmo: got %b/%b/%0d expected 1/0/3", done, pass, err_code); else n_ok++;
        // timeout beats pass on one generator
        enter_run();
        tg_timeout = 2'b01;
        tg_pass = 2'b11;
        tick(1);
        tg_timeout = 2'b00;
        tg_pass = 2'b00;
        n_chk++; if ({done, pass, err_code} !== {1'b1, 1'b0, 3'd4}) $display("FAIL tmo_over_pass: got %b/%b/%0d expected 1/0/4", done, pass, err_code); else n_ok++;
    endtask

    task automatic test_cal_timeout();
        pulse_start();
        tick(4);
        n_chk++; if (state !== 3'd2) $display("FAIL calt_enter: got %0d expected 2", state); else n_ok++;
        tick(19);
        n_chk++; if (state !== 3'd2) $display("FAIL calt_early: got %0d expected 2", state); else n_ok++;
        tick(1);
        n_chk++; if (state !== 3'd5) $display("FAIL calt_abort: got %0d expected 5", state); else n_ok++;
        n_chk++; if (err_code !== 3'd2) $display("FAIL calt_err: got %0d expected 2", err_code); else n_ok++;
        n_chk++; if ({hbm_reset_n, busy, done} !== 3'b001) $display("FAIL calt_outs: got %b expected 001", {hbm_reset_n, busy, done}); else n_ok++;
    endtask

    task automatic test_thermal();
        enter_run();
        cattrip = 1'b1;
        tg_pass = 2'b11;
        tick(1);
        cattrip = 1'b0;
        tg_pass = 2'b00;
        n_chk++; if ({state, pass, err_code} !== {3'd5, 1'b0, 3'd6}) $display("FAIL cattrip: got %0d/%b/%0d expected 5/0/6", state, pass, err_code); else n_ok++;
        n_chk++; if ({hbm_reset_n, tg_reset_n} !== 3'b000) $display("FAIL cattrip_resets: got %b expected 000", {hbm_reset_n, tg_reset_n}); else n_ok++;
        pulse_start();
        tick(4);
        temp = 3'd4;
        tick(1);
        n_chk++; if (state !== 3'd2) $display("FAIL temp_below: got %0d expected 2", state); else n_ok++;
        temp = 3'd5;
        tick(1);
        temp = 3'd0;
        n_chk++; if ({state, err_code} !== {3'd5, 3'd7}) $display("FAIL over_temp: got %0d/%0d expected 5/7", state, err_code); else n_ok++;
        // calibration failure aborts with err 1
        pulse_start();
        tick(4);
        cal_fail = 1'b1;
        cal_success = 1'b1;
        tick(1);
        cal_fail = 1'b0;
        cal_success = 1'b0;
        n_chk++; if ({state, err_code} !== {3'd5, 3'd1}) $display("FAIL cal_fail: got %0d/%0d expected 5/1", state, err_code); else n_ok++;
    endtask

    task automatic test_run_timeout();
        enter_run();
        tg_pass = 2'b01;
        tick(1);
        tg_pass = 2'b00;
        pulse_start();
        n_chk++; if ({state, busy} !== {3'd3, 1'b1}) $display("FAIL start_while_busy: got %0d/%b expected 3/1", state, busy); else n_ok++;
        tick(27);
        n_chk++; if (state !== 3'd3) $display("FAIL runt_early: got %0d expected 3", state); else n_ok++;
        tick(1);
        n_chk++; if ({state, err_code, done} !== {3'd5, 3'd5, 1'b1}) $display("FAIL runt_abort: got %0d/%0d/%b expected 5/5/1", state, err_code, done); else n_ok++;
        pulse_start();
        n_chk++; if ({state, done, busy, err_code} !== {3'd1, 1'b0, 1'b1, 3'd0}) $display("FAIL restart: got %0d/%b/%b/%0d expected 1/0/1/0", state, done, busy, err_code); else n_ok++;
    endtask

    task automatic test_async_reset();
        tick(4);
        cal_success = 1'b1;
        tick(1);
        cal_success = 1'b0;
        n_chk++; if (state !== 3'd3) $display("FAIL ar_in_run: got %0d expected 3", state); else n_ok++;
        #2;
        reset_reset_n = 1'b0;
        #1;
        n_chk++; if (state !== 3'd0) $display("FAIL ar_state: got %0d expected 0", state); else n_ok++;
        n_chk++; if ({hbm_reset_n, tg_reset_n} !== 3'b000) $display("FAIL ar_resets: got %b expected 000", {hbm_reset_n, tg_reset_n}); else n_ok++;
        n_chk++; if ({busy, done, pass, err_code} !== 6'b0) $display("FAIL ar_flags: got %b expected 000000", {busy, done, pass, err_code}); else n_ok++;
        tick(2);
        reset_reset_n = 1'b1;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_tg_fail();
        test_cal_timeout();
        test_thermal();
        test_run_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hbm_tg_run_ctrl.md
Name: hbm_tg_run_ctrl

Overview:
Run controller for the HBM example design. It holds the HBM controller and the two traffic generators (tg0_0, tg0_1) in reset. It then releases them in sequence, waits for calibration, and runs both generators. Per-generator pass/fail/timeout is aggregated into one verdict, and the run is aborted on catastrophic temperature trip (cattrip) or over-temperature from the m2u bridge. It sits between the board-level reset/start logic and the ed_synth reset and status conduits.

Parameters:
RESET_HOLD_CYCLES, 64, cycles hbm_reset_n is held low after start
CAL_TIMEOUT_CYCLES, 1000000, max cycles in WAIT_CAL before abort
RUN_TIMEOUT_CYCLES, 16000000, max cycles in RUN before abort
TEMP_LIMIT, 3'd5, abort when temp >= TEMP_LIMIT
CNT_W, 32, width of the shared cycle counter; must hold the largest timeout

Ports:
clk_clk  in  1  single clock for all logic
reset_reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a run
cal_success  in  1  HBM calibration passed (level)
cal_fail  in  1  HBM calibration failed (level)
cattrip  in  1  m2u bridge catastrophic trip (level)
temp  in  3  m2u bridge temperature code
tg_pass  in  2  traffic_gen_pass, bit0=tg0_0, bit1=tg0_1
tg_fail  in  2  traffic_gen_fail per generator
tg_timeout  in  2  traffic_gen_timeout per generator
hbm_reset_n  out  1  drives hbm_only_reset path, active-low
tg_reset_n  out  2  per-generator reset, active-low
busy  out  1  run in progress
done  out  1  run finished (sticky until next start)
pass  out  1  valid with done; both generators passed
err_code  out  3  0 none, 1 cal_fail, 2 cal_timeout, 3 tg_fail, 4 tg_timeout, 5 run_timeout, 6 cattrip, 7 over_temp
state  out  3  current FSM state encoding, debug

Behaviour:
- Reset (async assert, sync deassert internally) forces the following: state=IDLE, hbm_reset_n=0, tg_reset_n=2'b00, busy=0, done=0, pass=0, err_code=0, counter=0.
- All outputs are registered. Inputs are used directly; the integrator synchronises them to clk_clk.
- IDLE (0): all resets asserted. On start, go to RST_HOLD, clear done/pass/err_code, load counter=0, set busy=1.
- RST_HOLD (1): hbm_reset_n=0. Counter increments each cycle. When counter==RESET_HOLD_CYCLES-1, set hbm_reset_n=1, clear counter, go to WAIT_CAL.
- WAIT_CAL (2): the following are checked in priority order.
  - cal_fail: abort, err=1.
  - cal_success: set tg_reset_n=2'b11 on the next cycle, clear counter, go to RUN.
  - counter==CAL_TIMEOUT_CYCLES-1: abort, err=2.
- RUN (3): a generator is finished when its pass|fail|timeout is set. Finished flags are latched per generator. A generator's status is ignored once that generator is latched.
  - Any latched fail → err=3.
  - Else any latched timeout → err=4.
  - The verdict is evaluated when both generators are finished; this may happen in the same cycle or different cycles. If neither failed nor timed out, pass=1 and err=0.
  - If both flags are asserted on a generator in the same cycle, fail beats timeout, and timeout beats pass.
  - counter==RUN_TIMEOUT_CYCLES-1 with not both finished: abort, err=5.
  - On verdict, go to DONE.
- DONE (4): busy=0, done=1. tg_reset_n stays 2'b11 and hbm_reset_n stays 1, so status remains observable. start begins a new run: go to RST_HOLD, assert all resets, clear done/pass/err.
- ABORT (5): entered from RST_HOLD, WAIT_CAL or RUN.
  - On entry, hbm_reset_n=0, tg_reset_n=2'b00, busy=0, done=1, pass=0, err_code latched.
  - Stays here until start, then goes to RST_HOLD.
- Thermal monitor, active in RST_HOLD, WAIT_CAL and RUN:
  - cattrip=1 → abort, err=6.
  - Else temp>=TEMP_LIMIT → abort, err=7.
  - Thermal checks take priority over every other transition in the same cycle.
- start is ignored while busy=1.
- start coincident with reset deassertion is ignored.
- Counter saturates; it never wraps.
- Reset asserted mid-run returns to IDLE immediately and asynchronously, with all resets asserted.

Test Plan:
- Nominal run (RESET_HOLD_CYCLES=4): start pulse; cal_success at cycle 10; tg_pass=2'b01 at t, then 2'b11 at t+5. Expected: hbm_reset_n rises 4 cycles after start; tg_reset_n=11 one cycle after cal_success; done=1, pass=1, err_code=0 one cycle after the second pass.
- Generator failure: tg_fail[1] and tg_pass[0] in the same cycle. Expected: done=1, pass=0, err_code=3; tg_reset_n stays 11.
- Calibration timeout (CAL_TIMEOUT_CYCLES=20): cal_success never asserted. Expected: ABORT exactly 20 cycles after WAIT_CAL entry; err_code=2; hbm_reset_n=0.
- Thermal priority: in RUN, cattrip=1 and tg_pass=11 in the same cycle. Expected: err_code=6, pass=0. In a separate run, temp=5 while in WAIT_CAL gives err_code=7.
- Run timeout and restart (RUN_TIMEOUT_CYCLES=30): only tg0_0 passes. Expected: err_code=5 at cycle 30 of RUN. A start issued while busy is ignored; start after ABORT clears done and re-enters RST_HOLD.
- Async reset in RUN: drop reset_reset_n mid-cycle. Expected: all outputs take their reset values with no clock edge.
